maddsub_hilo_acc: RTL and testbench

Downstream combiner and sequencer for the 4-slice 32x32 DSP multiplier in MAddSub.
- Drives the clock enables of the four 16x16 partial-product slices (LL, LH, HL, HH).
- Sums their P outputs into a 64-bit product and applies signed correction.
- Owns the HI/LO registers and performs MULT/MULTU/MADD/MADDU/MSUB/MSUBU with a busy/done handshake to the EX stage.

---
 rtl/maddsub_pkg.sv | 30 +++
 rtl/maddsub_hilo_acc_pp_sum.sv | 44 ++++
 rtl/maddsub_hilo_acc.sv | 173 +++++++++++++++++
 tb/tb_maddsub_hilo_acc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/maddsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : maddsub_pkg                                                   |
// | Purpose  : Shared encodings and constants for the MAddSub HI/LO          |
// |            combiner: op_acc encodings, FSM states, default DSP latency,  |
// |            product width.                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package maddsub_pkg;

  // Operand capture (A1REG) + MREG + PREG
  localparam int DSP_LAT_DEFAULT = 3;
  localparam int PROD_W          = 64;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_RSVD = 2'b11   // behaves as MULT
  } op_acc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACC  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/maddsub_hilo_acc_pp_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : maddsub_pp_sum                                                |
// | Purpose  : Combinational sum of the four 16x16 unsigned partial products |
// |            into a 64-bit product, with two's-complement correction for   |
// |            signed operands.                                              |
// | Ports    : i_pp_ll/lh/hl/hh - slice P outputs (low 32 bits)             |
// |            i_a, i_b         - the operands the slices were fed           |
// |            i_is_signed      - 1 = signed multiply                        |
// |            o_s              - 64-bit product, modulo 2^64                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module maddsub_pp_sum
  import maddsub_pkg::*;
(
  input  logic [31:0]       i_pp_ll,
  input  logic [31:0]       i_pp_lh,
  input  logic [31:0]       i_pp_hl,
  input  logic [31:0]       i_pp_hh,
  input  logic [31:0]       i_a,
  input  logic [31:0]       i_b,
  input  logic              i_is_signed,
  output logic [PROD_W-1:0] o_s
);

  logic [PROD_W-1:0] w_u;
  logic [PROD_W-1:0] w_corr_a;
  logic [PROD_W-1:0] w_corr_b;

  // Cross terms are widened before adding so their carry is not lost.
  assign w_u = {32'b0, i_pp_ll}
             + ({32'b0, i_pp_lh} << 16)
             + ({32'b0, i_pp_hl} << 16)
             + {i_pp_hh, 32'b0};

  // (Au - a31*2^32)(Bu - b31*2^32) mod 2^64 drops the a31*b31*2^64 term,
  // leaving only the two cross corrections.
  assign w_corr_a = (i_is_signed && i_a[31]) ? {i_b, 32'b0} : '0;
  assign w_corr_b = (i_is_signed && i_b[31]) ? {i_a, 32'b0} : '0;

  assign o_s = w_u - w_corr_a - w_corr_b;

endmodule
`default_nettype wire

// File: rtl/maddsub_hilo_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : maddsub_hilo_acc                                              |
// | Purpose  : Sequencer and combiner for the 4-slice 32x32 DSP multiplier.  |
// |            Drives slice clock enables, sums the partial products and     |
// |            performs MULT/MADD/MSUB (signed/unsigned) into HI/LO with a   |
// |            busy/done handshake.                                          |
// | Ports    : clock, reset (async, active-low)                              |
// |            start, op_acc, op_unsigned, rs, rt  - operation request       |
// |            stall, abort                         - pipeline control       |
// |            hi_we, lo_we, wdata                  - MTHI/MTLO              |
// |            pp_ll/lh/hl/hh                       - slice P outputs        |
// |            ce_ab, ce_m, ce_p                    - slice clock enables    |
// |            busy, done, hi, lo                   - status and result      |
// | Config   : MADDSUB_MULT_BYPASS_EN - MULT/MULTU commit on the last WAIT   |
// |            cycle and skip ACC (one cycle shorter).                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module maddsub_hilo_acc
  import maddsub_pkg::*;
#(
  parameter int DSP_LAT = DSP_LAT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op_acc,
  input  logic        op_unsigned,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        stall,
  input  logic        abort,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic [31:0] pp_ll,
  input  logic [31:0] pp_lh,
  input  logic [31:0] pp_hl,
  input  logic [31:0] pp_hh,
  output logic        ce_ab,
  output logic        ce_m,
  output logic        ce_p,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int                CNT_W      = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DSP_LAT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [PROD_W-1:0] r_prod;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  op_acc_e           r_op;
  logic              r_uns;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic [PROD_W-1:0] w_s;
  logic [PROD_W-1:0] w_hilo;
  logic [PROD_W-1:0] w_commit;
  logic              w_last;
  logic              w_bypass;

  maddsub_pp_sum u_pp_sum (
    .i_pp_ll     (pp_ll),
    .i_pp_lh     (pp_lh),
    .i_pp_hl     (pp_hl),
    .i_pp_hh     (pp_hh),
    .i_a         (r_a),
    .i_b         (r_b),
    .i_is_signed (~r_uns),
    .o_s         (w_s)
  );

  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    w_commit = r_prod;
    case (r_op)
      OP_MADD: w_commit = w_hilo + r_prod;
      OP_MSUB: w_commit = w_hilo - r_prod;
      default: w_commit = r_prod;
    endcase
  end

  // Next-state and slice enables
  always_comb begin
    w_state_nxt = r_state;
    ce_ab       = 1'b0;
    ce_m        = 1'b0;
    ce_p        = 1'b0;
    w_last      = 1'b0;
    w_bypass    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so every output is quiet while reset is held.
        if (reset && start && !stall && !abort) begin
          ce_ab       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ce_m   = ~stall;
        ce_p   = ~stall;
        w_last = !stall && (r_count == c_cnt_last);
`ifdef MADDSUB_MULT_BYPASS_EN
        w_bypass = w_last && ((r_op == OP_MULT) || (r_op == OP_RSVD));
`endif
        // A bypassed MULT commits this cycle, so abort can no longer cancel it.
        if (w_bypass)    w_state_nxt = ST_DONE;
        else if (abort)  w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_ACC;
      end
      ST_ACC: begin
        if (!stall) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!stall) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_prod  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_MULT;
      r_uns   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (ce_ab) begin
            r_a     <= rs;
            r_b     <= rt;
            r_op    <= op_acc_e'(op_acc);
            r_uns   <= op_unsigned;
            r_count <= '0;
          end
        end
        ST_WAIT: begin
          if (!stall) r_count <= r_count + CNT_W'(1);
          if (w_last) r_prod <= w_s;
          if (w_bypass) {r_hi, r_lo} <= w_s;
        end
        ST_ACC: begin
          if (!stall) {r_hi, r_lo} <= w_commit;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_maddsub_hilo_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_maddsub_hilo_acc                                           |
// | Purpose  : Self-checking bench for maddsub_hilo_acc: table vectors,      |
// |            randomized ops against an arithmetic reference model, and     |
// |            hand sequences for stall, abort, busy hazards and reset.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_maddsub_hilo_acc;

  localparam int DSP_LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_acc = 2'b00;
  logic        op_unsigned = 1'b0;
  logic [31:0] rs = '0, rt = '0;
  logic        stall = 1'b0, abort = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] pp_ll = '0, pp_lh = '0, pp_hl = '0, pp_hh = '0;
  logic        ce_ab, ce_m, ce_p, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clock = ~clock;

  maddsub_hilo_acc #(.DSP_LAT(DSP_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .op_acc(op_acc),
    .op_unsigned(op_unsigned), .rs(rs), .rt(rt), .stall(stall), .abort(abort),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .pp_ll(pp_ll), .pp_lh(pp_lh), .pp_hl(pp_hl), .pp_hh(pp_hh),
    .ce_ab(ce_ab), .ce_m(ce_m), .ce_p(ce_p), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  // Slice model: operand, multiply and output registers gated by the enables.
  logic [31:0] s_a = '0, s_b = '0;
  logic [31:0] m_ll = '0, m_lh = '0, m_hl = '0, m_hh = '0;
  always @(posedge clock) begin
    if (ce_ab) begin s_a <= rs; s_b <= rt; end
    if (ce_m) begin
      m_ll <= s_a[15:0]  * s_b[15:0];
      m_lh <= s_a[15:0]  * s_b[31:16];
      m_hl <= s_a[31:16] * s_b[15:0];
      m_hh <= s_a[31:16] * s_b[31:16];
    end
    if (ce_p) begin pp_ll <= m_ll; pp_lh <= m_lh; pp_hl <= m_hl; pp_hh <= m_hh; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns);
    logic signed [63:0] sa, sb;
    if (uns) return {32'b0, a} * {32'b0, b};
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // MTHI (sel=1) or MTLO (sel=0) from IDLE.
  task automatic mt(input bit sel, input logic [31:0] d);
    hi_we = sel; lo_we = ~sel; wdata = d;
    if (sel) m_hi = d; else m_lo = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
  endtask

  // Runs one op from IDLE; cycle 0 is the accept cycle. Stall is held in
  // cycles [stall_at, stall_at+stall_len); at cycle poke_at a second start
  // and an MTLO are attempted while busy.
  task automatic run_op(input logic [1:0] op, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, input int stall_at, input int stall_len,
                        input int poke_at, input bit with_mthi, input logic [31:0] mthi_val);
    logic [63:0] p, acc;
    int lat;
    lat = DSP_LAT + 2 + stall_len;
`ifdef MADDSUB_MULT_BYPASS_EN
    if (op == 2'b00 || op == 2'b11) lat = lat - 1;
`endif
    start = 1'b1; op_acc = op; op_unsigned = uns; rs = a; rt = b;
    if (with_mthi) begin hi_we = 1'b1; wdata = mthi_val; m_hi = mthi_val; end
    #1;
    chk("ce_ab_accept", {63'b0, ce_ab}, 64'd1);
    chk("busy_c0", {63'b0, busy}, 64'd0);
    p = ref_prod(a, b, uns);
    acc = {m_hi, m_lo};
    case (op)
      2'b01:   acc = acc + p;
      2'b10:   acc = acc - p;
      default: acc = p;
    endcase
    for (int c = 1; c <= lat; c++) begin
      tick();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      if (c == poke_at) begin
        start = 1'b1; rs = ~a; rt = b + 32'd1; lo_we = 1'b1; wdata = 32'h1234_5678;
      end
      #1;
      chk("busy_run", {63'b0, busy}, 64'd1);
      chk("done_timing", {63'b0, done}, {63'b0, (c == lat)});
      if (stall) begin
        chk("ce_m_stalled", {63'b0, ce_m}, 64'd0);
        chk("ce_p_stalled", {63'b0, ce_p}, 64'd0);
      end
      if (c == poke_at) chk("ce_ab_busy", {63'b0, ce_ab}, 64'd0);
    end
    start = 1'b0; lo_we = 1'b0; wdata = '0; stall = 1'b0;
    chk("hilo_result", {hi, lo}, acc);
    {m_hi, m_lo} = acc;
    tick();
    chk("idle_after", {62'b0, busy, done}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        uns;
    logic [31:0] a, b, hi0, lo0, ehi, elo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h00000001};
    tbl[2] = '{2'b00, 1'b0, 32'h80000000, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000000};
    tbl[3] = '{2'b01, 1'b1, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[4] = '{2'b10, 1'b1, 32'h2, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[5] = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'h5, 32'h0, 32'hA, 32'h00000000, 32'h00000005};
    tbl[6] = '{2'b11, 1'b0, 32'h7, 32'h6, 32'h1, 32'h1, 32'h00000000, 32'h0000002A};
    tbl[7] = '{2'b10, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[8] = '{2'b00, 1'b1, 32'h3, 32'h5, 32'h7, 32'h7, 32'h00000000, 32'h0000000F};

    // Reset state
    start = 1'b1;
    repeat (3) tick();
    #1;
    chk("reset_outputs", {58'b0, ce_ab, ce_m, ce_p, busy, done, 1'b0}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      mt(1'b1, tbl[i].hi0);
      mt(1'b0, tbl[i].lo0);
      run_op(tbl[i].op, tbl[i].uns, tbl[i].a, tbl[i].b, 0, 0, 0, 1'b0, '0);
      chk($sformatf("table_%0d", i), {hi, lo}, {tbl[i].ehi, tbl[i].elo});
    end

    // Stall for two WAIT cycles
    mt(1'b1, 32'h0); mt(1'b0, 32'h0);
    run_op(2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2, 0, 1'b0, '0);
    chk("stall_result", {hi, lo}, 64'hFFFFFFFE_00000001);

    // start and MTLO while busy are dropped (MADD so lo matters)
    run_op(2'b01, 1'b1, 32'h10, 32'h10, 0, 0, 2, 1'b0, '0);

    // MTHI in the accept cycle is seen by the accumulate
    mt(1'b1, 32'h0); mt(1'b0, 32'h0);
    run_op(2'b01, 1'b1, 32'h1, 32'h1, 0, 0, 0, 1'b1, 32'h5);
    chk("mthi_with_start", {hi, lo}, 64'h00000005_00000001);

    // Randomized ops
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 4) == 0) rb = 32'hFFFFFFFF;
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb,
             2, $urandom_range(0, 2), 0, 1'b0, '0);
    end

    // Abort in cycle 2 of MADD
    start = 1'b1; op_acc = 2'b01; op_unsigned = 1'b0; rs = 32'h3; rt = 32'h4;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    chk("abort_idle", {63'b0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, {m_hi, m_lo});
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_done", {63'b0, done}, 64'd0);
      tick();
    end

    // Reset while in ACC
    start = 1'b1; op_acc = 2'b01; op_unsigned = 1'b1; rs = 32'h9; rt = 32'h9;
    tick();
    start = 1'b0;
    repeat (DSP_LAT) tick();
    reset = 1'b0;
    #1;
    chk("rst_acc_busy", {62'b0, busy, done}, 64'd0);
    chk("rst_acc_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    tick();
    run_op(2'b00, 1'b1, 32'h3, 32'h5, 0, 0, 0, 1'b0, '0);
    chk("after_reset_op", {hi, lo}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
